// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared constants, state enum and divisor mux for the serial link
package spart_pkg;

  localparam int DIV_0_DEF = 20833;
  localparam int DIV_1_DEF = 10417;
  localparam int DIV_2_DEF = 5208;
  localparam int DIV_3_DEF = 2604;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Picks the clk-cycles-per-bit value for the requested baud selection
  function automatic logic [14:0] div_sel(input logic [1:0] br,
                                          input int d0, input int d1,
                                          input int d2, input int d3);
    logic [14:0] v;
    case (br)
      2'b00:   v = 15'(d0);
      2'b01:   v = 15'(d1);
      2'b10:   v = 15'(d2);
      default: v = 15'(d3);
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rs232_host_rx.sv
// rtl/rs232_host_rx.sv - 8N1 receiver with input synchronizer and mid-bit sampling
module rs232_host_rx
  import spart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ser_in,
  input  logic [14:0] div,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_frame_err
);

  // [0] and [1] form the synchronizer, [2] is the previous synced value for edge detect
  logic [2:0]  r_sync;
  state_t      r_state;
  logic [14:0] r_div;
  logic [14:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_rx_err;

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_frame_err = r_rx_err;

  // Bring the asynchronous line into the clk domain; idle level is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 3'b111;
    else     r_sync <= {r_sync[1:0], ser_in};
  end

  // Receive FSM: half-bit wait to the start-bit centre, then one sample per bit period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_sync[2] && !r_sync[1]) begin
            r_div   <= div;
            r_cnt   <= div >> 1;
            r_state <= START;
          end
        end
        START: begin
          if (r_cnt == '0) begin
            if (r_sync[1]) begin
              r_state <= IDLE;
            end else begin
              r_cnt   <= r_div - 15'd1;
              r_bit   <= '0;
              r_state <= DATA;
            end
          end else begin
            r_cnt <= r_cnt - 15'd1;
          end
        end
        DATA: begin
          if (r_cnt == '0) begin
            r_shift <= {r_sync[1], r_shift[7:1]};
            r_cnt   <= r_div - 15'd1;
            if (r_bit == 3'(DATA_BITS - 1)) r_state <= STOP;
            else                            r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt - 15'd1;
          end
        end
        STOP: begin
          if (r_cnt == '0) begin
            if (r_sync[1] == STOP_LEVEL) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_rx_err   <= 1'b1;
            end
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 15'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rs232_host.sv
// rtl/rs232_host.sv - far-end RS232 endpoint: inline 8N1 transmitter plus receiver instance
module rs232_host
  import spart_pkg::*;
#(
  parameter int DIV_0 = DIV_0_DEF,
  parameter int DIV_1 = DIV_1_DEF,
  parameter int DIV_2 = DIV_2_DEF,
  parameter int DIV_3 = DIV_3_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       ser_in,
  output logic       ser_out,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  logic [14:0] w_div;
  state_t      r_state;
  logic [14:0] r_div;
  logic [14:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_ser_out;
  logic        r_tx_ready;

  assign w_div    = div_sel(br_cfg, DIV_0, DIV_1, DIV_2, DIV_3);
  assign ser_out  = r_ser_out;
  assign tx_ready = r_tx_ready;

  // Transmit FSM: each phase holds the line for exactly one latched divisor period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_ser_out  <= 1'b1;
      r_tx_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_tx_ready && tx_valid) begin
            r_shift    <= tx_data;
            r_div      <= w_div;
            r_cnt      <= '0;
            r_ser_out  <= 1'b0;
            r_tx_ready <= 1'b0;
            r_state    <= START;
          end else begin
            r_ser_out  <= 1'b1;
            r_tx_ready <= 1'b1;
          end
        end
        START: begin
          if (r_cnt == r_div - 15'd1) begin
            r_cnt     <= '0;
            r_bit     <= '0;
            r_ser_out <= r_shift[0];
            r_state   <= DATA;
          end else begin
            r_cnt <= r_cnt + 15'd1;
          end
        end
        DATA: begin
          if (r_cnt == r_div - 15'd1) begin
            r_cnt <= '0;
            if (r_bit == 3'(DATA_BITS - 1)) begin
              r_ser_out <= STOP_LEVEL;
              r_state   <= STOP;
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_ser_out <= r_shift[1];
              r_bit     <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 15'd1;
          end
        end
        STOP: begin
          if (r_cnt == r_div - 15'd1) begin
            r_cnt      <= '0;
            r_tx_ready <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt + 15'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  rs232_host_rx u_rx (
    .clk          (clk),
    .rst          (rst),
    .ser_in       (ser_in),
    .div          (w_div),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

endmodule

// File: doc/rs232_host.md
Name: rs232_host

Overview:
- Behavioural-but-synthesizable RS232 endpoint for the far end of the serial link.
- Its ser_in connects to the SPART txd and its ser_out drives the SPART rxd.
- It lets a bench or a second FPGA inject bytes into the SPART and capture the bytes the SPART emits, with the same br_cfg baud selection as the driver.
- Format is fixed at 8N1, LSB first, idle high.

Parameters:
- DIV_0, 20833, clk cycles per bit for br_cfg=00 (4800 baud at 100 MHz)
- DIV_1, 10417, clk cycles per bit for br_cfg=01 (9600)
- DIV_2, 5208, clk cycles per bit for br_cfg=10 (19200)
- DIV_3, 2604, clk cycles per bit for br_cfg=11 (38400)

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-high reset
- br_cfg  input  2  baud select; sampled only when the respective engine is idle
- ser_in  input  1  serial data from SPART txd (asynchronous to clk)
- ser_out  output  1  serial data to SPART rxd
- tx_data  input  8  byte to send
- tx_valid  input  1  tx request
- tx_ready  output  1  high when the TX engine is idle and will accept tx_data
- rx_data  output  8  last received byte
- rx_valid  output  1  one-cycle pulse: rx_data is updated
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset (async, rst=1) forces: ser_out=1, tx_ready=0, rx_data=8'h00, rx_valid=0, rx_frame_err=0, both FSMs to IDLE, all counters 0, synchronizer flops 1.
- tx_ready rises the first clk edge after rst deasserts.
- Divisor: DIV = DIV_n per br_cfg, latched into a 15-bit register at transaction start. A br_cfg change mid-byte has no effect until the next byte.

TX FSM, states IDLE, START, DATA, STOP:
- IDLE: tx_ready=1, ser_out=1. When tx_valid&tx_ready, latch tx_data and DIV, tx_ready drops next cycle, go START.
- START: ser_out=0 for DIV cycles.
- DATA: ser_out=shift[0] for DIV cycles per bit, bits 0..7, 3-bit bit counter.
- STOP: ser_out=1 for DIV cycles, then IDLE.
- Total frame is exactly 10*DIV cycles from the cycle after acceptance. Back-to-back bytes are legal: accept in the IDLE cycle and the next start bit follows 1 cycle after stop ends.
- tx_valid while tx_ready=0 is ignored; no queueing.

RX FSM, states IDLE, START, DATA, STOP:
- ser_in goes through a 2-flop synchronizer; all RX decisions use the synchronized value (2-cycle latency).
- IDLE: on a synced 1->0 transition, latch DIV, go START, counter=DIV/2 (integer shift).
- START: at mid-bit, if the synced line is 1 it is a glitch; return to IDLE with no pulse. Otherwise reload DIV, go DATA.
- DATA: sample at each bit centre (every DIV cycles), shift in LSB first, 8 samples.
- STOP: sample at centre.
  - Line 1: rx_data<=shift, rx_valid=1 for 1 cycle.
  - Line 0: rx_frame_err=1 for 1 cycle; rx_data is unchanged.
  - Either way return to IDLE immediately after the stop-bit centre sample. A following start edge is detectable from the next cycle.
- RX and TX are fully independent; simultaneous activity is legal (full duplex).
- Reset mid-frame aborts both engines at once. ser_out returns high asynchronously and no partial rx pulse is produced.

Decomposition:
- Shared package spart_pkg:
  - DIV_x default constants
  - 2-bit state enum (IDLE/START/DATA/STOP) used by both FSMs
  - frame constants: DATA_BITS=8, STOP_LEVEL=1
- Natural sub-module: rs232_host_rx, holding the synchronizer, RX FSM and mid-bit counter, instanced once.
- TX stays inline in rs232_host.
- Divisor mux function lives in spart_pkg.

Test Plan:
- Reset then idle: rst=1 for 22 ns, release -> ser_out=1, tx_ready=1 one cycle after release, no rx pulses for 50 us.
- TX byte 8'h55, br_cfg=01 with DIV_1 overridden to 16 -> ser_out low 16 cycles, then 1,0,1,0,1,0,1,0 each 16 cycles, stop high 16 cycles; tx_ready high again at cycle 161 after acceptance.
- RX byte 8'hA5 driven on ser_in with DIV=16, LSB first -> rx_valid pulses once, rx_data=8'hA5, about 9.5*16+2 cycles after the falling edge; rx_frame_err stays 0.
- Framing error: 8'h3C with stop bit held low -> rx_frame_err single pulse, rx_valid stays 0, rx_data keeps the previous value 8'hA5.
- Glitch: ser_in low for 5 cycles (DIV=16) -> no rx_valid, FSM back in IDLE, next good byte 8'h0F received correctly.
- Loopback to the SPART: rs232_host ser_out->rxd, txd->ser_in, br_cfg=11. Host sends 8'h41 -> driver echo returns 8'h41 on rx_data. Assert rst mid-byte -> ser_out=1 immediately and tx_ready=1 after release.
